// File: rtl/lu_pkg.sv
// ============================================================================
//  Module      : lu_pkg
//  Description : Shared constants for the logic-unit operation identifier:
//                3-bit select codes of the 8-operation logic unit, the 4-bit
//                truth table each operation produces (bit k is the result for
//                {a,b} = k), and the identifier FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package lu_pkg;

    // Logic unit select codes
    localparam logic [2:0] LU_NOT_A = 3'b000;
    localparam logic [2:0] LU_NOT_B = 3'b001;
    localparam logic [2:0] LU_AND   = 3'b010;
    localparam logic [2:0] LU_NAND  = 3'b011;
    localparam logic [2:0] LU_OR    = 3'b100;
    localparam logic [2:0] LU_NOR   = 3'b101;
    localparam logic [2:0] LU_XOR   = 3'b110;
    localparam logic [2:0] LU_XNOR  = 3'b111;

    // Truth tables, bit k = result for {a,b} = k
    localparam logic [3:0] LU_TT_NOT_A = 4'b0011;
    localparam logic [3:0] LU_TT_NOT_B = 4'b0101;
    localparam logic [3:0] LU_TT_AND   = 4'b1000;
    localparam logic [3:0] LU_TT_NAND  = 4'b0111;
    localparam logic [3:0] LU_TT_OR    = 4'b1110;
    localparam logic [3:0] LU_TT_NOR   = 4'b0001;
    localparam logic [3:0] LU_TT_XOR   = 4'b0110;
    localparam logic [3:0] LU_TT_XNOR  = 4'b1001;

    // Identifier FSM encoding
    localparam logic [1:0] LU_ST_IDLE     = 2'd0;
    localparam logic [1:0] LU_ST_DRIVE    = 2'd1;
    localparam logic [1:0] LU_ST_CLASSIFY = 2'd2;
    localparam logic [1:0] LU_ST_DONE     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = LU_ST_IDLE,
        ST_DRIVE    = LU_ST_DRIVE,
        ST_CLASSIFY = LU_ST_CLASSIFY,
        ST_DONE     = LU_ST_DONE
    } lu_state_e;

endpackage : lu_pkg

`default_nettype wire

// File: rtl/lu_table_decode.sv
// ============================================================================
//  Module      : lu_table_decode
//  Description : Combinational decoder from a captured 4-bit truth table to
//                the logic unit select code. Tables that match none of the
//                eight operations give match_o = 0 and op_code_o = 000.
//  Ports       : truth_i   [3:0] in  captured table, bit k = result at {a,b}=k
//                op_code_o [2:0] out decoded select code
//                match_o         out table is one of the eight operations
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lu_table_decode
    import lu_pkg::*;
(
    input  logic [3:0] truth_i,
    output logic [2:0] op_code_o,
    output logic       match_o
);

    always_comb begin
        op_code_o = LU_NOT_A;
        match_o   = 1'b1;
        case (truth_i)
            LU_TT_NOT_A: op_code_o = LU_NOT_A;
            LU_TT_NOT_B: op_code_o = LU_NOT_B;
            LU_TT_AND:   op_code_o = LU_AND;
            LU_TT_NAND:  op_code_o = LU_NAND;
            LU_TT_OR:    op_code_o = LU_OR;
            LU_TT_NOR:   op_code_o = LU_NOR;
            LU_TT_XOR:   op_code_o = LU_XOR;
            LU_TT_XNOR:  op_code_o = LU_XNOR;
            default: begin
                op_code_o = 3'b000;
                match_o   = 1'b0;
            end
        endcase
    end

endmodule : lu_table_decode

`default_nettype wire

// File: rtl/lu_op_identifier.sv
// ============================================================================
//  Module      : lu_op_identifier
//  Description : Sequential identifier for the 8-operation, 2-input logic
//                unit. Sweeps the unit's a/b operands through {a,b} = 0..3,
//                samples the unit's result at each point, then decodes the
//                captured truth table back into the 3-bit select code.
//  Parameters  : SETTLE_CYCLES  extra hold cycles per point (0..15)
//  Build macro : LU_ID_DOUBLE_SAMPLE_EN  sample each point on its last two
//                edges and flag disagreement on `unstable`; when undefined a
//                single sample is taken and `unstable` is tied to 0.
//  Ports       : clk            in   rising-edge clock
//                reset          in   asynchronous active-high reset
//                start          in   one-cycle sweep request
//                rsp_result     in   logic unit result
//                drv_a, drv_b   out  operands driven to the logic unit
//                busy           out  sweep in progress
//                done           out  one-cycle completion pulse
//                truth    [3:0] out  captured table
//                op_code  [2:0] out  decoded select code
//                match          out  table is a legal operation
//                unstable       out  sample disagreement seen
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lu_op_identifier
    import lu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rsp_result,
    output logic       drv_a,
    output logic       drv_b,
    output logic       busy,
    output logic       done,
    output logic [3:0] truth,
    output logic [2:0] op_code,
    output logic       match,
    output logic       unstable
);

`ifdef LU_ID_DOUBLE_SAMPLE_EN
    // One extra hold cycle per point provides the earlier sample edge.
    localparam logic [4:0] HOLD_LAST  = 5'(SETTLE_CYCLES + 1);
    localparam logic [4:0] FIRST_SAMP = 5'(SETTLE_CYCLES);
`else
    localparam logic [4:0] HOLD_LAST  = 5'(SETTLE_CYCLES);
`endif

    lu_state_e  state_q, state_d;
    logic [1:0] k_q, k_d;
    logic [4:0] cnt_q, cnt_d;
    logic [3:0] truth_q, truth_d;
    logic [2:0] op_q, op_d;
    logic       match_q, match_d;
`ifdef LU_ID_DOUBLE_SAMPLE_EN
    logic       unstable_q, unstable_d;
    logic       first_q, first_d;
`endif

    logic [2:0] dec_op;
    logic       dec_match;
    logic       classify_block;

    lu_table_decode u_decode (
        .truth_i   (truth_q),
        .op_code_o (dec_op),
        .match_o   (dec_match)
    );

`ifdef LU_ID_DOUBLE_SAMPLE_EN
    assign classify_block = unstable_q;
`else
    assign classify_block = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        truth_d    = truth_q;
        op_d       = op_q;
        match_d    = match_q;
`ifdef LU_ID_DOUBLE_SAMPLE_EN
        unstable_d = unstable_q;
        first_d    = first_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE accepts a new request exactly like IDLE so sweeps can
                // run back to back without an idle gap.
                if (start) begin
                    state_d    = ST_DRIVE;
                    k_d        = 2'd0;
                    cnt_d      = 5'd0;
                    truth_d    = 4'b0000;
                    op_d       = 3'b000;
                    match_d    = 1'b0;
`ifdef LU_ID_DOUBLE_SAMPLE_EN
                    unstable_d = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                    k_d     = 2'd0;
                    cnt_d   = 5'd0;
                end
            end

            ST_DRIVE: begin
`ifdef LU_ID_DOUBLE_SAMPLE_EN
                if (cnt_q == FIRST_SAMP) begin
                    first_d = rsp_result;
                end
`endif
                if (cnt_q == HOLD_LAST) begin
                    truth_d[k_q] = rsp_result;
`ifdef LU_ID_DOUBLE_SAMPLE_EN
                    if (first_q != rsp_result) begin
                        unstable_d = 1'b1;
                    end
`endif
                    cnt_d = 5'd0;
                    // k stays at 3 so the operands hold 1/1 until IDLE.
                    if (k_q == 2'd3) begin
                        state_d = ST_CLASSIFY;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end

            ST_CLASSIFY: begin
                op_d    = classify_block ? 3'b000 : dec_op;
                match_d = dec_match & ~classify_block;
                state_d = ST_DONE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            k_q        <= 2'd0;
            cnt_q      <= 5'd0;
            truth_q    <= 4'b0000;
            op_q       <= 3'b000;
            match_q    <= 1'b0;
`ifdef LU_ID_DOUBLE_SAMPLE_EN
            unstable_q <= 1'b0;
            first_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            truth_q    <= truth_d;
            op_q       <= op_d;
            match_q    <= match_d;
`ifdef LU_ID_DOUBLE_SAMPLE_EN
            unstable_q <= unstable_d;
            first_q    <= first_d;
`endif
        end
    end

    // Operands come straight from the point index register, which is 0 in
    // IDLE and parked at 3 through CLASSIFY and DONE.
    assign drv_a   = k_q[1];
    assign drv_b   = k_q[0];
    assign busy    = (state_q == ST_DRIVE) || (state_q == ST_CLASSIFY);
    assign done    = (state_q == ST_DONE);
    assign truth   = truth_q;
    assign op_code = op_q;
    assign match   = match_q;
`ifdef LU_ID_DOUBLE_SAMPLE_EN
    assign unstable = unstable_q;
`else
    assign unstable = 1'b0;
`endif

endmodule : lu_op_identifier

`default_nettype wire

// File: tb/tb_lu_op_identifier.sv
// ============================================================================
//  Module      : tb_lu_op_identifier
//  Description : Self-checking bench for lu_op_identifier. A behavioural model
//                of the 8-operation logic unit (or a fixed table) answers the
//                identifier's operand drive; expected tables and codes come
//                from a vector table and from a search-based reference decoder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lu_op_identifier;

    localparam int S = 1;
`ifdef LU_ID_DOUBLE_SAMPLE_EN
    localparam int HOLD = S + 2;
`else
    localparam int HOLD = S + 1;
`endif
    localparam int LAT = 4 * HOLD + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       rsp_result;
    logic       drv_a, drv_b, busy, done, match, unstable;
    logic [3:0] truth;
    logic [2:0] op_code;

    // Responder: logic unit model, fixed table, or forced override.
    logic       use_sel = 1'b1;
    logic [2:0] sel     = 3'b000;
    logic [3:0] tab     = 4'b0000;
    logic       ovr_en  = 1'b0;
    logic       ovr_val = 1'b0;

    int errors = 0;
    int checks = 0;

    lu_op_identifier #(.SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rsp_result (rsp_result),
        .drv_a      (drv_a),
        .drv_b      (drv_b),
        .busy       (busy),
        .done       (done),
        .truth      (truth),
        .op_code    (op_code),
        .match      (match),
        .unstable   (unstable)
    );

    always #5 clk = ~clk;

    function automatic logic lu_eval(input logic [2:0] s, input logic a, input logic b);
        case (s)
            3'd0:    return ~a;
            3'd1:    return ~b;
            3'd2:    return a & b;
            3'd3:    return ~(a & b);
            3'd4:    return a | b;
            3'd5:    return ~(a | b);
            3'd6:    return a ^ b;
            default: return ~(a ^ b);
        endcase
    endfunction

    always_comb begin
        rsp_result = 1'b0;
        if (ovr_en)       rsp_result = ovr_val;
        else if (use_sel) rsp_result = lu_eval(sel, drv_a, drv_b);
        else              rsp_result = tab[{drv_a, drv_b}];
    end

    function automatic logic [3:0] ref_table(input logic [2:0] s);
        logic [3:0] t;
        logic [1:0] kk;
        t = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            kk   = 2'(k);
            t[k] = lu_eval(s, kk[1], kk[0]);
        end
        return t;
    endfunction

    // Returns {match, op_code}: search all eight operations for the table.
    function automatic logic [3:0] ref_id(input logic [3:0] t);
        for (int s = 0; s < 8; s++) begin
            if (ref_table(3'(s)) == t) return {1'b1, 3'(s)};
        end
        return 4'b0000;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues start, follows the sweep to done and checks the result.
    // pulse_at >= 0 re-pulses start at that cycle of the sweep;
    // toggle3 flips rsp_result between the two samples of point 3.
    task automatic run_sweep(input string tag, input logic [3:0] et,
                             input logic [2:0] eo, input logic em,
                             input logic eu, input int pulse_at,
                             input bit toggle3);
        int j;
        bit drv_ok;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ":busy_rise"}, {busy, done}, 2);
        j = 0;
        drv_ok = 1'b1;
        while (!done && j < LAT + 20) begin
            if (j < 4 * HOLD) begin
                if ({drv_a, drv_b} != 2'(j / HOLD)) drv_ok = 1'b0;
            end else if ({drv_a, drv_b} != 2'b11) begin
                drv_ok = 1'b0;
            end
            start = (j == pulse_at);
            if (toggle3 && j == 4 * HOLD - 2) begin
                ovr_en  = 1'b1;
                ovr_val = 1'b0;
            end else if (toggle3 && j == 4 * HOLD - 1) begin
                ovr_val = 1'b1;
            end else begin
                ovr_en = 1'b0;
            end
            tick();
            j++;
        end
        start  = 1'b0;
        ovr_en = 1'b0;
        if ({drv_a, drv_b} != 2'b11) drv_ok = 1'b0;
        chk({tag, ":latency"}, j, LAT);
        chk({tag, ":drv_seq"}, drv_ok, 1);
        chk({tag, ":truth"}, truth, et);
        chk({tag, ":op_code"}, op_code, eo);
        chk({tag, ":match"}, match, em);
        chk({tag, ":unstable"}, unstable, eu);
        chk({tag, ":busy_at_done"}, busy, 0);
    endtask

    typedef struct {
        bit         use_sel;
        logic [2:0] sel;
        logic [3:0] tab;
        logic [3:0] et;
        logic [2:0] eo;
        logic       em;
    } vec_t;

    vec_t vt[11];

    initial begin
        vt[0]  = '{1'b1, 3'b000, 4'b0000, 4'b0011, 3'b000, 1'b1};
        vt[1]  = '{1'b1, 3'b001, 4'b0000, 4'b0101, 3'b001, 1'b1};
        vt[2]  = '{1'b1, 3'b010, 4'b0000, 4'b1000, 3'b010, 1'b1};
        vt[3]  = '{1'b1, 3'b011, 4'b0000, 4'b0111, 3'b011, 1'b1};
        vt[4]  = '{1'b1, 3'b100, 4'b0000, 4'b1110, 3'b100, 1'b1};
        vt[5]  = '{1'b1, 3'b101, 4'b0000, 4'b0001, 3'b101, 1'b1};
        vt[6]  = '{1'b1, 3'b110, 4'b0000, 4'b0110, 3'b110, 1'b1};
        vt[7]  = '{1'b1, 3'b111, 4'b0000, 4'b1001, 3'b111, 1'b1};
        vt[8]  = '{1'b0, 3'b000, 4'b0000, 4'b0000, 3'b000, 1'b0};
        vt[9]  = '{1'b0, 3'b000, 4'b1111, 4'b1111, 3'b000, 1'b0};
        vt[10] = '{1'b0, 3'b000, 4'b1010, 4'b1010, 3'b000, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        tick();
        tick();
        chk("reset_outputs", {drv_a, drv_b, busy, done, truth, op_code, match, unstable}, 0);
        reset = 1'b0;
        tick();

        // Basic XOR identification.
        use_sel = 1'b1;
        sel = 3'b110;
        run_sweep("xor", 4'b0110, 3'b110, 1'b1, 1'b0, -1, 1'b0);
        tick();
        chk("idle_drv", {drv_a, drv_b, busy, done}, 0);
        chk("idle_hold", {truth, op_code, match}, {4'b0110, 3'b110, 1'b1});
        tick();

        // Vector table, back to back (start asserted during DONE).
        for (int i = 0; i < 11; i++) begin
            use_sel = vt[i].use_sel;
            sel     = vt[i].sel;
            tab     = vt[i].tab;
            run_sweep($sformatf("vec%0d", i), vt[i].et, vt[i].eo, vt[i].em, 1'b0, -1, 1'b0);
        end
        tick();

        // Random operations and random tables against the reference decoder.
        for (int i = 0; i < 24; i++) begin
            logic [3:0] et;
            logic [3:0] id;
            use_sel = 1'($urandom_range(0, 1));
            sel     = 3'($urandom_range(0, 7));
            tab     = 4'($urandom_range(0, 15));
            et      = use_sel ? ref_table(sel) : tab;
            id      = ref_id(et);
            run_sweep($sformatf("rnd%0d", i), et, id[2:0], id[3], 1'b0, -1, 1'b0);
        end
        tick();
        tick();

        // Reset in the middle of a sweep.
        use_sel = 1'b1;
        sel = 3'b110;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 5; j++) tick();
        reset = 1'b1;
        tick();
        chk("midreset_outputs", {drv_a, drv_b, busy, done, truth, op_code, match, unstable}, 0);
        reset = 1'b0;
        tick();
        sel = 3'b101;
        run_sweep("after_reset", 4'b0001, 3'b101, 1'b1, 1'b0, -1, 1'b0);
        tick();

        // start while busy is ignored.
        sel = 3'b011;
        run_sweep("busy_start", 4'b0111, 3'b011, 1'b1, 1'b0, 3, 1'b0);
        begin
            int extra_done;
            extra_done = 0;
            for (int j = 0; j < LAT + 4; j++) begin
                tick();
                if (done || busy) extra_done++;
            end
            chk("busy_start:no_restart", extra_done, 0);
        end

`ifdef LU_ID_DOUBLE_SAMPLE_EN
        // Disagreeing samples on point 3 with the AND operation.
        sel = 3'b010;
        run_sweep("unstable", 4'b1000, 3'b000, 1'b0, 1'b1, -1, 1'b1);
        tick();
        sel = 3'b010;
        run_sweep("stable_again", 4'b1000, 3'b010, 1'b1, 1'b0, -1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_lu_op_identifier

`default_nettype wire

// File: doc/lu_op_identifier.md
# lu_op_identifier

Sequential identifier for the 8-operation, 2-input logic unit (NOT a, NOT b, AND, NAND, OR, NOR, XOR, XNOR selected by a 3-bit code). The block drives the unit's `a`/`b` inputs through all four combinations, samples the unit's `result` at each one, and decodes the captured 4-bit truth table back into the 3-bit select code. It sits on the observing side of the logic unit and serves as a self-check and identification engine.

## Interface
- `SETTLE_CYCLES`, default 1: extra hold cycles per operand point before sampling; legal range 0..15.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle request to begin a sweep.
- `rsp_result`  in  1: the logic unit's `result` output.
- `drv_a`  out  1: operand `a` driven to the logic unit.
- `drv_b`  out  1: operand `b` driven to the logic unit.
- `busy`  out  1: high while a sweep is in progress.
- `done`  out  1: one-cycle pulse when a sweep completes.
- `truth`  out  4: captured table; `truth[k]` is the result for `{a,b} = k`.
- `op_code`  out  3: decoded select code; valid when `match` = 1.
- `match`  out  1: captured table equals one of the 8 legal operations.
- `unstable`  out  1: sample disagreement (see Configuration).

## Operation
- FSM states: IDLE, DRIVE, CLASSIFY, DONE.
- IDLE: `busy`=0. If `start`=1, go to DRIVE with point index k=0 and clear `truth`, `match`, `op_code`, and `unstable`.
- DRIVE: `drv_a`=k[1], `drv_b`=k[0]. A hold counter runs 0..SETTLE_CYCLES. On the edge where the counter equals SETTLE_CYCLES, `truth[k]` <= `rsp_result`.
  - If k<3: increment k and reset the counter.
  - If k=3: go to CLASSIFY.
- CLASSIFY (1 cycle): decode `truth` and register `op_code`/`match`. Go to DONE.
- DONE (1 cycle): `done`=1, `busy`=0. A `start` here is accepted exactly as in IDLE. Otherwise go to IDLE.
- Decode table, `truth` to `op_code`:
  - 0011 → 000 (NOT a)
  - 0101 → 001 (NOT b)
  - 1000 → 010 (AND)
  - 0111 → 011 (NAND)
  - 1110 → 100 (OR)
  - 0001 → 101 (NOR)
  - 0110 → 110 (XOR)
  - 1001 → 111 (XNOR)
  - Any other table: `match`=0 and `op_code`=000.
- `start` while `busy`=1 is ignored.
- `truth`, `op_code`, `match`, and `unstable` hold their values from DONE until the next accepted `start`.

## Timing
- Reset values: state IDLE, k=0, counter=0.
  - All outputs 0: `drv_a`, `drv_b`, `busy`, `done`, `truth`=0000, `op_code`=000, `match`, `unstable`.
- `busy` rises on the edge that accepts `start`.
- Each operand point is held for SETTLE_CYCLES+1 cycles.
- `done` is high 4·(SETTLE_CYCLES+1)+1 cycles after the accepting edge; with the default setting, that is 9 cycles.
- `drv_a`/`drv_b` are registered and change only on the edge that follows a sample. They stay at 1/1 through CLASSIFY and DONE, then return to 0/0 in IDLE.
- `rsp_result` is treated as synchronous and stable by the sampling edge; the block adds no synchronizer.
- Reset asserted mid-sweep: immediate return to reset values, and the partial `truth` is discarded.

## Configuration
- `LU_ID_DOUBLE_SAMPLE_EN` defined:
  - Each point is held SETTLE_CYCLES+2 cycles.
  - `rsp_result` is sampled on the last two edges of the point.
  - If any point's two samples differ, `unstable`=1 and, in CLASSIFY, `match` is forced to 0 and `op_code` to 000.
  - `truth[k]` takes the later sample.
  - Latency becomes 4·(SETTLE_CYCLES+2)+1.
- Macro undefined: single sample per point, and `unstable` is tied to 0. The port is present in both builds.

## Structure
- Package `lu_pkg`:
  - 3-bit opcode localparams `LU_NOT_A` … `LU_XNOR` (000–111).
  - The eight 4-bit truth-table constants.
  - FSM state enum.
- Sub-module `lu_table_decode`: purely combinational, `truth[3:0]` → `op_code[2:0]`, `match`. It is instantiated once in CLASSIFY's input path.

## Test plan
- Bench ties the block to the 8-op logic unit with select=110; pulse `start`:
  - `done` at cycle 9, `truth`=0110, `op_code`=110, `match`=1.
  - Drive sequence is (0,0), (0,1), (1,0), (1,1), each held 2 cycles.
- Sweep all 8 select codes back-to-back, with `start` asserted during DONE: each sweep returns its own code with `match`=1 and no idle gap.
- `rsp_result` tied to 0: `truth`=0000, `match`=0, `op_code`=000.
- Reset asserted at cycle 5 of a sweep: all outputs are 0 on the following cycle, and a subsequent `start` completes normally.
- `start` pulsed at cycle 3 of an active sweep: ignored, with no restart and no second `done`.
- With `LU_ID_DOUBLE_SAMPLE_EN` and select=010 (AND), toggle `rsp_result` between the two samples of point 3:
  - `unstable`=1, `match`=0.
  - `done` at cycle 13.
